// File: rtl/dlatch_bank.sv
// CHANNELS x WIDTH flop-based hold registers with per-channel enable glitch filter, level/pulse capture, global freeze.
// Latency: capture lands in q on the (FILTER+1)th consecutive en-high edge; updated strobes the cycle after a changed capture.
// No backpressure: lock freezes every channel. Optional par output is built only when DLATCH_BANK_PARITY_EN is defined.
module dlatch_bank #(
    parameter int               WIDTH     = 8,
    parameter int               CHANNELS  = 4,
    parameter int               FILTER    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       en,
    input  logic                      mode,
    input  logic                      lock,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       updated
`ifdef DLATCH_BANK_PARITY_EN
    ,
    output logic [CHANNELS-1:0]       par
`endif
);

    localparam int            CW   = $clog2(FILTER + 1) + 1;
    localparam logic [CW-1:0] FILT = CW'(FILTER);

    typedef enum logic [1:0] {IDLE, ARM, OPEN, HELD} state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           st, st_nxt;
        logic [CW-1:0]    cnt, cnt_nxt;
        logic             cap;
        logic             upd_r;
        logic [WIDTH-1:0] d_ch, q_r;

        assign d_ch                  = d[i*WIDTH +: WIDTH];
        assign q[i*WIDTH +: WIDTH]   = q_r;
        assign updated[i]            = upd_r;

        always_comb begin
            st_nxt  = st;
            cnt_nxt = cnt;
            cap     = 1'b0;
            unique case (st)
                IDLE: begin
                    if (en[i]) begin
                        if (FILTER == 0) begin
                            cap    = 1'b1;
                            st_nxt = mode ? HELD : OPEN;
                        end else begin
                            st_nxt  = ARM;
                            cnt_nxt = CW'(1);
                        end
                    end
                end
                ARM: begin
                    if (!en[i]) begin
                        st_nxt  = IDLE;
                        cnt_nxt = '0;
                    end else if (cnt == FILT) begin
                        cap    = 1'b1;
                        st_nxt = mode ? HELD : OPEN;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                OPEN: begin
                    if (!en[i]) begin
                        st_nxt  = IDLE;
                        cnt_nxt = '0;
                    end else if (mode) begin
                        st_nxt = HELD;
                    end else begin
                        cap = 1'b1;
                    end
                end
                HELD: begin
                    // Switching back to level mode reopens without capturing on this edge.
                    if (!en[i]) begin
                        st_nxt  = IDLE;
                        cnt_nxt = '0;
                    end else if (!mode) begin
                        st_nxt = OPEN;
                    end
                end
                default: begin
                    st_nxt  = IDLE;
                    cnt_nxt = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                st    <= IDLE;
                cnt   <= '0;
                q_r   <= RESET_VAL;
                upd_r <= 1'b0;
            end else if (lock) begin
                upd_r <= 1'b0;
            end else begin
                st    <= st_nxt;
                cnt   <= cnt_nxt;
                upd_r <= cap && (d_ch != q_r);
                if (cap) begin
                    q_r <= d_ch;
                end
            end
        end

`ifdef DLATCH_BANK_PARITY_EN
        logic par_r;
        assign par[i] = par_r;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                par_r <= ^RESET_VAL;
            end else if (!lock && cap) begin
                par_r <= ^d_ch;
            end
        end
`endif
    end

endmodule

// File: tb/tb_dlatch_bank.sv
// Scoreboard bench: two dlatch_bank instances (FILTER=2 and FILTER=0) share random/directed stimulus.
// Expected q/updated come from a run-length model of the enable history, popped by an independent monitor.
module tb_dlatch_bank;

    localparam logic [7:0] RV = 8'hA5;

    logic        clk = 1'b0;
    logic        rstn, mode, lock;
    logic [31:0] d;
    logic [3:0]  en;
    logic [31:0] q2, q0;
    logic [3:0]  u2, u0;
`ifdef DLATCH_BANK_PARITY_EN
    logic [3:0]  p2, p0;
`endif

    always #5 clk = ~clk;

    dlatch_bank #(.WIDTH(8), .CHANNELS(4), .FILTER(2), .RESET_VAL(RV)) dut2 (
        .clk(clk), .rstn(rstn), .d(d), .en(en), .mode(mode), .lock(lock),
        .q(q2), .updated(u2)
`ifdef DLATCH_BANK_PARITY_EN
        , .par(p2)
`endif
    );

    dlatch_bank #(.WIDTH(8), .CHANNELS(4), .FILTER(0), .RESET_VAL(RV)) dut0 (
        .clk(clk), .rstn(rstn), .d(d), .en(en), .mode(mode), .lock(lock),
        .q(q0), .updated(u0)
`ifdef DLATCH_BANK_PARITY_EN
        , .par(p0)
`endif
    );

    typedef struct packed {
        logic [31:0] q2;
        logic [3:0]  u2;
        logic [31:0] q0;
        logic [3:0]  u0;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Model: run = consecutive unlocked en-high edges; lmode = mode seen at the previous such edge.
    int          run   [2][4];
    logic        lmode [2][4];
    logic [7:0]  mq    [2][4];
    logic [3:0]  mu    [2];

    task automatic model_edge();
        exp_t       e;
        int         filt;
        logic [7:0] dc;
        logic       capt;
        for (int k = 0; k < 2; k++) begin
            filt = (k == 0) ? 2 : 0;
            for (int c = 0; c < 4; c++) begin
                dc   = d[c*8 +: 8];
                capt = 1'b0;
                if (!rstn) begin
                    mq[k][c]  = RV;
                    run[k][c] = 0;
                    mu[k][c]  = 1'b0;
                end else if (lock) begin
                    mu[k][c] = 1'b0;
                end else if (!en[c]) begin
                    run[k][c] = 0;
                    mu[k][c]  = 1'b0;
                end else begin
                    if (run[k][c] < filt + 2) run[k][c]++;
                    capt = (run[k][c] == filt + 1) ||
                           (run[k][c] > filt + 1 && !mode && !lmode[k][c]);
                    lmode[k][c] = mode;
                    mu[k][c]    = capt && (dc != mq[k][c]);
                    if (capt) mq[k][c] = dc;
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            e.q2[c*8 +: 8] = mq[0][c];
            e.q0[c*8 +: 8] = mq[1][c];
        end
        e.u2 = mu[0];
        e.u0 = mu[1];
        sb.push_back(e);
    endtask

    task automatic step(input logic [31:0] dv, input logic [3:0] ev,
                        input logic mv, input logic lv, input logic rv);
        @(negedge clk);
        d = dv; en = ev; mode = mv; lock = lv; rstn = rv;
        model_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every edge is an output event; compare against the oldest pending expectation.
    initial begin
        exp_t       e;
        logic [3:0] pe2, pe0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (q2 !== e.q2) begin n_err++; $display("FAIL sb_q_f2 got %h want %h", q2, e.q2); end
                if (u2 !== e.u2) begin n_err++; $display("FAIL sb_upd_f2 got %b want %b", u2, e.u2); end
                if (q0 !== e.q0) begin n_err++; $display("FAIL sb_q_f0 got %h want %h", q0, e.q0); end
                if (u0 !== e.u0) begin n_err++; $display("FAIL sb_upd_f0 got %b want %b", u0, e.u0); end
                for (int c = 0; c < 4; c++) begin
                    pe2[c] = ^e.q2[c*8 +: 8];
                    pe0[c] = ^e.q0[c*8 +: 8];
                end
`ifdef DLATCH_BANK_PARITY_EN
                if (p2 !== pe2) begin n_err++; $display("FAIL sb_par_f2 got %b want %b", p2, pe2); end
                if (p0 !== pe0) begin n_err++; $display("FAIL sb_par_f0 got %b want %b", p0, pe0); end
`endif
            end
        end
    end

    initial begin
        logic [31:0] dv;
        logic [3:0]  ev;
        logic        mr;
        rstn = 1'b0; mode = 1'b0; lock = 1'b0; en = '0; d = '0;

        for (int i = 0; i < 3; i++) step($urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        chk("reset_q_f2", q2, {4{RV}});
        chk("reset_q_f0", q0, {4{RV}});
        chk("reset_upd", {28'd0, u2 | u0}, 32'd0);

        dv = {4{RV}};
        step(dv, 4'b0000, 1'b0, 1'b0, 1'b1);
        step(dv, 4'b0000, 1'b0, 1'b0, 1'b1);
        chk("post_reset_hold", q2, {4{RV}});

        dv[7:0] = 8'h3C;
        step(dv, 4'b0001, 1'b0, 1'b0, 1'b1);
        step(dv, 4'b0001, 1'b0, 1'b0, 1'b1);
        chk("filt_edge2_q0", {24'd0, q2[7:0]}, {24'd0, RV});
        step(dv, 4'b0001, 1'b0, 1'b0, 1'b1);
        chk("filt_edge3_q0", {24'd0, q2[7:0]}, 32'h3C);
        chk("filt_edge3_upd", {28'd0, u2}, 32'h1);
        dv[7:0] = 8'h3D;
        step(dv, 4'b0001, 1'b0, 1'b0, 1'b1);
        chk("level_edge4_q0", {24'd0, q2[7:0]}, 32'h3D);
        chk("others_hold", {8'd0, q2[31:8]}, {8'd0, {3{RV}}});
        step(dv, 4'b0000, 1'b0, 1'b0, 1'b1);

        dv[15:8] = 8'h55;
        step(dv, 4'b0010, 1'b0, 1'b0, 1'b1);
        step(dv, 4'b0010, 1'b0, 1'b0, 1'b1);
        step(dv, 4'b0000, 1'b0, 1'b0, 1'b1);
        chk("short_en_no_cap", {24'd0, q2[15:8]}, {24'd0, RV});
        chk("short_en_no_upd", {31'd0, u2[1]}, 32'd0);
        for (int i = 0; i < 3; i++) step(dv, 4'b0010, 1'b0, 1'b0, 1'b1);
        chk("reassert_cap", {24'd0, q2[15:8]}, 32'h55);
        step(dv, 4'b0000, 1'b0, 1'b0, 1'b1);

        for (int i = 1; i <= 5; i++) begin
            dv[23:16] = 8'(i);
            step(dv, 4'b0100, 1'b1, 1'b0, 1'b1);
            if (i == 1) chk("pulse_first_upd", {31'd0, u0[2]}, 32'd1);
            if (i == 2) chk("pulse_no_restrobe", {31'd0, u0[2]}, 32'd0);
        end
        chk("pulse_q_f0", {24'd0, q0[23:16]}, 32'h01);
        chk("pulse_q_f2", {24'd0, q2[23:16]}, 32'h03);
        step(dv, 4'b0000, 1'b1, 1'b0, 1'b1);
        dv[23:16] = 8'h09;
        step(dv, 4'b0100, 1'b1, 1'b0, 1'b1);
        chk("pulse_recapture", {24'd0, q0[23:16]}, 32'h09);
        step(dv, 4'b0000, 1'b0, 1'b0, 1'b1);

        dv[31:24] = 8'h10;
        step(dv, 4'b1000, 1'b0, 1'b0, 1'b1);
        dv[31:24] = 8'h11;
        step(dv, 4'b1000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            dv[31:24] = 8'(8'h20 + i);
            step(dv, 4'b1000, 1'b0, 1'b1, 1'b1);
            chk("lock_freeze", {24'd0, q0[31:24]}, 32'h11);
        end
        chk("lock_no_upd", {28'd0, u0}, 32'd0);
        dv[31:24] = 8'h30;
        step(dv, 4'b1000, 1'b0, 1'b0, 1'b1);
        chk("lock_release_track", {24'd0, q0[31:24]}, 32'h30);
        step(dv, 4'b1000, 1'b0, 1'b1, 1'b0);
        chk("reset_over_lock", q0, {4{RV}});

        dv[7:0] = 8'h07;
        step(dv, 4'b0001, 1'b0, 1'b0, 1'b1);
        chk("par_cap07_q", {24'd0, q0[7:0]}, 32'h07);
`ifdef DLATCH_BANK_PARITY_EN
        chk("par_cap07", {31'd0, p0[0]}, 32'd1);
`endif
        dv[7:0] = 8'h03;
        step(dv, 4'b0001, 1'b0, 1'b0, 1'b1);
`ifdef DLATCH_BANK_PARITY_EN
        chk("par_cap03", {31'd0, p0[0]}, 32'd0);
`endif

        mr = 1'b0;
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < 4; c++) begin
                dv[c*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
                ev[c]        = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 4) == 0) mr = ~mr;
            step(dv, ev, mr, ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) != 0));
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain pending %0d want 0", sb.size());
        end
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
